// File: rtl/sram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port SRAM.
// Optional burst locking is enabled by defining SRAM_ARB_BURST_LOCK_EN.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   mN_req/we/last/addr/wdata : master N request (N = 0,1)
//   mN_gnt     : combinational grant; transfer completes on req & gnt
//   mN_rvalid  : one-cycle pulse, read data for master N
//   mN_rdata   : i_rdata while mN_rvalid, else zero
//   o_we/o_waddr/o_wdata/o_raddr : SRAM native port outputs
//   i_rdata    : SRAM read data, valid one cycle after read grant
module sram_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_last,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_last,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic [AW-1:0] o_raddr,
  input  logic [DW-1:0] i_rdata
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [1:0]    arb;
  logic          any;
  logic          sel;
  logic          we_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;
  logic          ptr_q, ptr_d;
  logic [1:0]    rv_q, rv_d;

  assign req = {m1_req, m0_req};

  // Plain round-robin choice; ptr_q names the favoured master.
  always_comb begin
    arb = req;
    if (&req) begin
      arb = ptr_q ? 2'b10 : 2'b01;
    end
  end

`ifdef SRAM_ARB_BURST_LOCK_EN
  typedef enum logic [1:0] {
    UNLOCKED,
    LOCK0,
    LOCK1
  } lock_e;

  lock_e lock_q, lock_d;
  logic  last_s;

  // A held lock shuts out the other master even if the owner idles.
  always_comb begin
    gnt = '0;
    unique case (lock_q)
      LOCK0:   gnt[0] = req[0];
      LOCK1:   gnt[1] = req[1];
      default: gnt = arb;
    endcase
    gnt = gnt & {2{rst_n}};
  end

  assign last_s = sel ? m1_last : m0_last;

  always_comb begin
    lock_d = lock_q;
    ptr_d  = ptr_q;
    if (any) begin
      unique case (lock_q)
        UNLOCKED: begin
          if (!last_s) lock_d = sel ? LOCK1 : LOCK0;
          else         ptr_d  = ~sel;
        end
        default: begin
          if (last_s) begin
            lock_d = UNLOCKED;
            ptr_d  = ~sel;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= UNLOCKED;
    else        lock_q <= lock_d;
  end
`else
  logic unused_last;

  assign unused_last = ^{m0_last, m1_last};
  assign gnt = arb & {2{rst_n}};

  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = ~sel;
  end
`endif

  assign any     = |gnt;
  assign sel     = gnt[1];
  assign we_s    = sel ? m1_we    : m0_we;
  assign addr_s  = sel ? m1_addr  : m0_addr;
  assign wdata_s = sel ? m1_wdata : m0_wdata;

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign o_we    = any & we_s;
  assign o_waddr = any ? addr_s  : '0;
  assign o_wdata = any ? wdata_s : '0;
  assign o_raddr = any ? addr_s  : '0;

  assign rv_d[0] = gnt[0] & ~m0_we;
  assign rv_d[1] = gnt[1] & ~m1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      rv_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      rv_q  <= rv_d;
    end
  end

  assign m0_rvalid = rv_q[0];
  assign m1_rvalid = rv_q[1];
  assign m0_rdata  = rv_q[0] ? i_rdata : '0;
  assign m1_rdata  = rv_q[1] ? i_rdata : '0;

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, meaning SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning SRAM data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for each of m0 and m1, ports mN_req in 1, mN_we in 1, mN_last in 1, mN_addr in AW, mN_wdata in DW, mN_gnt out 1, mN_rvalid out 1, mN_rdata out DW.
REQ-006 SHALL have SRAM-side ports o_we out 1, o_waddr out AW, o_wdata out DW, o_raddr out AW, i_rdata in DW; these match the native port of axi4_sram.

Function
REQ-007 SHALL complete a transfer on master N in any cycle where mN_req and mN_gnt are both high; requests SHALL be held stable until granted.
REQ-008 SHALL assert at most one of m0_gnt and m1_gnt in any cycle; mN_gnt SHALL be low whenever mN_req is low.
REQ-009 SHALL derive gnt combinationally from req and the registered priority/lock state (zero-cycle grant).
REQ-010 SHALL grant a lone requester immediately, regardless of priority pointer.
REQ-011 SHALL, when both request and no lock is held, grant the master named by the round-robin pointer.
REQ-012 SHALL, after every completed transfer, set the pointer to the master that did not transfer.
REQ-013 SHALL drive o_we = granted master's we AND grant; o_waddr, o_wdata, o_raddr from the granted master; all zero when no grant.
REQ-014 SHALL treat i_rdata as valid exactly one cycle after a read grant; mN_rvalid SHALL pulse high for that one cycle only for the master that issued the read.
REQ-015 SHALL drive mN_rdata from i_rdata when mN_rvalid is high and zero otherwise.
REQ-016 SHALL support back-to-back reads by alternating masters with one rvalid per cycle and no bubbles.
REQ-017 SHALL, on a write and a read to the same address in consecutive cycles, return whatever the SRAM returns (no forwarding).
REQ-018 SHALL ignore mN_we, mN_addr, mN_wdata, mN_last while mN_req is low.

Reset
REQ-019 SHALL, while rst_n is low, force m0_gnt=0, m1_gnt=0, o_we=0, m0_rvalid=0, m1_rvalid=0, pointer=m0, lock state=UNLOCKED.
REQ-020 SHALL, on reset asserted mid-operation, drop any pending rvalid and any held lock; no transfer SHALL complete in the first cycle after rst_n deasserts unless req is high that cycle.

Configuration
REQ-021 SHALL, when macro SRAM_ARB_BURST_LOCK_EN is defined, implement burst locking with states UNLOCKED, LOCK0, LOCK1.
REQ-022 SHALL, with the macro, enter LOCKN from UNLOCKED on a completed mN transfer with mN_last=0.
REQ-023 SHALL, with the macro, grant only mN while in LOCKN, even if mN_req drops and the other master requests.
REQ-024 SHALL, with the macro, return from LOCKN to UNLOCKED on a completed mN transfer with mN_last=1, and apply REQ-012 only at that point.
REQ-025 SHALL, without the macro, ignore mN_last, contain no lock state, and arbitrate per transfer.

Verification
REQ-026 SHALL cover: reset, then m0 write addr 0x010 data 0xDEADBEEF alone -> m0_gnt same cycle, o_we=1, o_waddr=0x010, o_wdata=0xDEADBEEF.
REQ-027 SHALL cover: both masters reading continuously (m0 addr 0x001, m1 addr 0x002) -> grants alternate m0,m1,m0,...; rvalid alternates one cycle later with matching data.
REQ-028 SHALL cover: m1 read of 0x020 granted, i_rdata=0x12345678 next cycle -> m1_rvalid=1, m1_rdata=0x12345678, m0_rvalid=0.
REQ-029 SHALL cover (SRAM_ARB_BURST_LOCK_EN): m0 4-beat burst, last on beat 4, m1 requesting throughout -> m1_gnt low for 4 transfers, m1 granted in cycle after beat 4.
REQ-030 SHALL cover: rst_n pulsed low mid-lock with read outstanding -> rvalid not asserted, lock cleared, m1 granted on first post-reset cycle when only m1 requests.
